control_unit: RTL

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/mini_src_pkg.sv | 54 +++++
 rtl/instr_decode.sv | 44 ++++
 rtl/control_unit.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/mini_src_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mini_src_pkg
// Description : Opcode, ALU code, instruction class and FSM state definitions
//               shared by the control unit and its instruction decoder.
// Revision    : 1.0
// ============================================================================
package mini_src_pkg;

    localparam logic [4:0] C_OP_LD   = 5'b00000;
    localparam logic [4:0] C_OP_ST   = 5'b00010;
    localparam logic [4:0] C_OP_ADD  = 5'b00011;
    localparam logic [4:0] C_OP_SUB  = 5'b00100;
    localparam logic [4:0] C_OP_AND  = 5'b00101;
    localparam logic [4:0] C_OP_OR   = 5'b00110;
    localparam logic [4:0] C_OP_ADDI = 5'b01100;
    localparam logic [4:0] C_OP_ANDI = 5'b01101;
    localparam logic [4:0] C_OP_ORI  = 5'b01110;
    localparam logic [4:0] C_OP_BR   = 5'b10010;
    localparam logic [4:0] C_OP_JR   = 5'b10011;
    localparam logic [4:0] C_OP_HALT = 5'b11011;

    localparam logic [4:0] C_ALU_ADD = 5'b00011;
    localparam logic [4:0] C_ALU_SUB = 5'b00100;
    localparam logic [4:0] C_ALU_AND = 5'b00101;
    localparam logic [4:0] C_ALU_OR  = 5'b00110;
    localparam logic [4:0] C_ALU_INC = 5'b11111;

    typedef enum logic [3:0] {
        ST_RESET = 4'd0,
        ST_T0    = 4'd1,
        ST_T1    = 4'd2,
        ST_T2    = 4'd3,
        ST_T3    = 4'd4,
        ST_T4    = 4'd5,
        ST_T5    = 4'd6,
        ST_T6    = 4'd7,
        ST_T7    = 4'd8,
        ST_HALT  = 4'd9
    } state_t;

    typedef enum logic [2:0] {
        CLS_RTYPE   = 3'd0,
        CLS_IMM     = 3'd1,
        CLS_LD      = 3'd2,
        CLS_ST      = 3'd3,
        CLS_BR      = 3'd4,
        CLS_JR      = 3'd5,
        CLS_HALT    = 3'd6,
        CLS_ILLEGAL = 3'd7
    } instr_class_t;

endpackage
`default_nettype wire

// File: rtl/instr_decode.sv
`default_nettype none
// ============================================================================
// Module      : instr_decode
// Description : Classifies an opcode and maps immediate ops to their ALU code.
// Revision    : 1.0
// ============================================================================
module instr_decode
    import mini_src_pkg::*;
#(
    parameter int OPC_W = 5
) (
    input  logic [4:0]       i_opcode,
    output instr_class_t     o_class,
    output logic [OPC_W-1:0] o_imm_alu
);

    always_comb begin
        o_class   = CLS_ILLEGAL;
        o_imm_alu = '0;
        case (i_opcode)
            C_OP_ADD, C_OP_SUB, C_OP_AND, C_OP_OR: o_class = CLS_RTYPE;
            C_OP_ADDI: begin
                o_class   = CLS_IMM;
                o_imm_alu = OPC_W'(C_ALU_ADD);
            end
            C_OP_ANDI: begin
                o_class   = CLS_IMM;
                o_imm_alu = OPC_W'(C_ALU_AND);
            end
            C_OP_ORI: begin
                o_class   = CLS_IMM;
                o_imm_alu = OPC_W'(C_ALU_OR);
            end
            C_OP_LD:   o_class = CLS_LD;
            C_OP_ST:   o_class = CLS_ST;
            C_OP_BR:   o_class = CLS_BR;
            C_OP_JR:   o_class = CLS_JR;
            C_OP_HALT: o_class = CLS_HALT;
            default:   o_class = CLS_ILLEGAL;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
// Module      : control_unit
// Description : Multi-cycle control FSM generating datapath/memory strobes.
// Revision    : 1.0
// ============================================================================
module control_unit
    import mini_src_pkg::*;
#(
    parameter int OPC_W = 5
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [31:0]      ir,
    input  logic             con_ff,
    input  logic             mem_ready,
    output logic             Pout,
    output logic             Pen,
    output logic             IncPC,
    output logic             MARen,
    output logic             MDRen,
    output logic             MDROut,
    output logic             IRen,
    output logic             Yen,
    output logic             Zen,
    output logic             ZLOout,
    output logic             Cout,
    output logic             Read,
    output logic             Write,
    output logic             Gra,
    output logic             Grb,
    output logic             Grc,
    output logic             Rin,
    output logic             Rout,
    output logic             BAout,
    output logic             ConIn,
    output logic [OPC_W-1:0] alu_control,
    output logic             run,
    output logic             illegal
);

    state_t             state_q, state_d;
    logic               t1_first_q, t1_first_d;
    logic               illegal_q, illegal_d;
    instr_class_t       w_class;
    logic [OPC_W-1:0]   w_imm_alu;
    logic [4:0]         w_opcode;
    logic               w_unused_ir;

    assign w_opcode    = ir[31:27];
    assign w_unused_ir = ^ir[26:0];

    instr_decode #(.OPC_W(OPC_W)) u_instr_decode (
        .i_opcode (w_opcode),
        .o_class  (w_class),
        .o_imm_alu(w_imm_alu)
    );

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        case (state_q)
            ST_RESET: state_d = ST_T0;
            ST_T0:    state_d = ST_T1;
            ST_T1:    if (mem_ready) state_d = ST_T2;
            ST_T2:    state_d = ST_T3;
            ST_T3: begin
                case (w_class)
                    CLS_JR:   state_d = ST_T0;
                    CLS_HALT: begin
                        state_d   = ST_HALT;
                        illegal_d = 1'b0;
                    end
                    CLS_ILLEGAL: begin
                        state_d   = ST_HALT;
                        illegal_d = 1'b1;
                    end
                    default:  state_d = ST_T4;
                endcase
            end
            ST_T4:    state_d = ST_T5;
            ST_T5:    state_d = (w_class == CLS_RTYPE || w_class == CLS_IMM) ? ST_T0 : ST_T6;
            ST_T6: begin
                if (w_class == CLS_LD)      state_d = mem_ready ? ST_T7 : ST_T6;
                else if (w_class == CLS_ST) state_d = ST_T7;
                else                        state_d = ST_T0;
            end
            ST_T7: begin
                if (w_class == CLS_ST && !mem_ready) state_d = ST_T7;
                else                                 state_d = ST_T0;
            end
            ST_HALT:  state_d = ST_HALT;
            default:  state_d = ST_RESET;
        endcase
        // Pen in T1 fires only on the entry cycle, however long the fetch waits.
        t1_first_d = (state_d == ST_T1) && (state_q != ST_T1);
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q    <= ST_RESET;
            t1_first_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            t1_first_q <= t1_first_d;
            illegal_q  <= illegal_d;
        end
    end

    always_comb begin
        {Pout, Pen, IncPC, MARen, MDRen, MDROut, IRen, Yen, Zen, ZLOout, Cout} = '0;
        {Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, ConIn} = '0;
        alu_control = '0;
        run         = (state_q != ST_RESET) && (state_q != ST_HALT);
        illegal     = (state_q == ST_HALT) && illegal_q;
        case (state_q)
            ST_T0: begin
                {Pout, MARen, IncPC, Zen} = 4'b1111;
                alu_control = OPC_W'(C_ALU_INC);
            end
            ST_T1: {ZLOout, Read, MDRen, Pen} = {3'b111, t1_first_q};
            ST_T2: {MDROut, IRen} = 2'b11;
            ST_T3: begin
                case (w_class)
                    CLS_RTYPE, CLS_IMM: {Grb, Rout, Yen}   = 3'b111;
                    CLS_LD, CLS_ST:     {Grb, BAout, Yen}  = 3'b111;
                    CLS_BR:             {Gra, Rout, ConIn} = 3'b111;
                    CLS_JR:             {Gra, Rout, Pen}   = 3'b111;
                    default: ;
                endcase
            end
            ST_T4: begin
                case (w_class)
                    CLS_RTYPE: begin
                        {Grc, Rout, Zen} = 3'b111;
                        alu_control = OPC_W'(w_opcode);
                    end
                    CLS_IMM: begin
                        {Cout, Zen} = 2'b11;
                        alu_control = w_imm_alu;
                    end
                    CLS_LD, CLS_ST: begin
                        {Cout, Zen} = 2'b11;
                        alu_control = OPC_W'(C_ALU_ADD);
                    end
                    CLS_BR: {Pout, Yen} = 2'b11;
                    default: ;
                endcase
            end
            ST_T5: begin
                case (w_class)
                    CLS_RTYPE, CLS_IMM: {ZLOout, Gra, Rin} = 3'b111;
                    CLS_LD, CLS_ST:     {ZLOout, MARen}    = 2'b11;
                    CLS_BR: begin
                        {Cout, Zen} = 2'b11;
                        alu_control = OPC_W'(C_ALU_ADD);
                    end
                    default: ;
                endcase
            end
            ST_T6: begin
                case (w_class)
                    CLS_LD: {Read, MDRen} = 2'b11;
                    CLS_ST: {Gra, Rout, MDRen} = 3'b111;
                    CLS_BR: {ZLOout, Pen} = {con_ff, con_ff};
                    default: ;
                endcase
            end
            ST_T7: begin
                if (w_class == CLS_LD)      {MDROut, Gra, Rin} = 3'b111;
                else if (w_class == CLS_ST) Write = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire
